// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product over WIDTH RUN cycles.
// Define SEQ_MULTIPLIER_SIGNED_EN for two's-complement operands (magnitude multiply plus sign fix-up).
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operandA,
  input  logic [WIDTH-1:0]   operandB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one add/shift per cycle, WIDTH cycles
  // DONE  | one cycle, done pulse, product valid; start here is accepted
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic                 accept;
  logic [WIDTH-1:0]     opa_mag;
  logic [WIDTH-1:0]     opb_mag;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   res_d;

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Lower half of the accumulator holds the multiplier; it shifts out as the product shifts in.
  always_comb begin
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
  end

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic sign_q;

  assign opa_mag = operandA[WIDTH-1] ? (~operandA + 1'b1) : operandA;
  assign opb_mag = operandB[WIDTH-1] ? (~operandB + 1'b1) : operandB;
  assign res_d   = sign_q ? (~acc_d + 1'b1) : acc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q <= 1'b0;
    end else if (accept) begin
      sign_q <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
    end
  end
`else
  assign opa_mag = operandA;
  assign opb_mag = operandB;
  assign res_d   = acc_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            mcand_q <= opa_mag;
            acc_q   <= {{WIDTH{1'b0}}, opb_mag};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            product_q <= res_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier; expected products are hand-computed for the
// unsigned build and, with SEQ_MULTIPLIER_SIGNED_EN defined, for the signed build.
module tb_seq_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] operandA;
  logic [15:0] operandB;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_exp;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  localparam logic [31:0] E_FFFF_FFFF = 32'h0000_0001;
  localparam logic [31:0] E_8000_0002 = 32'hFFFF_0000;
  localparam logic [31:0] E_FFFD_0005 = 32'hFFFF_FFF1;
`else
  localparam logic [31:0] E_FFFF_FFFF = 32'hFFFE_0001;
  localparam logic [31:0] E_8000_0002 = 32'h0001_0000;
  localparam logic [31:0] E_FFFD_0005 = 32'h0004_FFF1;
`endif

  seq_multiplier #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .operandA (operandA),
    .operandB (operandB),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called just after the start edge; returns edges until done and busy cycles seen.
  task automatic wait_done(output int k, output int busy_n);
    k = 0;
    busy_n = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    operandA = a;
    operandB = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    operandA = 16'h5A5A;
    operandB = 16'hA5A5;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string tag);
    int k, bn;
    launch(a, b);
    wait_done(k, bn);
    check({tag, "_latency"}, k, 16);
    check({tag, "_busy_cycles"}, bn, 16);
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold"}, product, exp);
    last_exp = exp;
  endtask

  initial begin
    int k, bn, pulses;
    reset    = 1'b1;
    start    = 1'b0;
    operandA = '0;
    operandB = '0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    reset = 1'b0;

    do_op(16'd3, 16'd5, 32'd15, "basic");
    repeat (3) @(negedge clk);
    check("basic_hold_late", product, 32'd15);

    do_op(16'd0, 16'h1234, 32'd0, "zero");
    do_op(16'hFFFF, 16'hFFFF, E_FFFF_FFFF, "max");
    do_op(16'h8000, 16'h0002, E_8000_0002, "sign");
    do_op(16'h8000, 16'h8000, 32'h4000_0000, "range");
    do_op(16'hFFFD, 16'h0005, E_FFFD_0005, "neg3x5");

    // start while busy must be ignored
    launch(16'd2, 16'd3);
    repeat (4) @(negedge clk);
    operandA = 16'd7;
    operandB = 16'd7;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("busy_start_prod_mid", product, last_exp);
    wait_done(k, bn);
    check("busy_start_latency", k + 5, 16);
    check("busy_start_product", product, 32'd6);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("busy_start_extra_done", pulses, 0);
    check("busy_start_hold", product, 32'd6);

    // back-to-back: second start in DONE cycle
    launch(16'd4, 16'd4);
    wait_done(k, bn);
    check("b2b_first_latency", k, 16);
    check("b2b_first_product", product, 32'd16);
    operandA = 16'd10;
    operandB = 16'd10;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("b2b_busy_after_start", {31'b0, busy}, 32'd1);
    check("b2b_prod_held", product, 32'd16);
    wait_done(k, bn);
    check("b2b_second_latency", k, 16);
    check("b2b_second_product", product, 32'd100);

    // reset mid-operation
    launch(16'd100, 16'd100);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_product", product, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    bn = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) bn++;
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_no_busy", bn, 0);
    check("midrst_product_after", product, 32'd0);

    do_op(16'd3, 16'd5, 32'd15, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
